sig_pack: RTL and testbench



---
 rtl/sig_pack.sv | 148 ++++++++++++++
 tb/tb_sig_pack.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sig_pack.sv
// rtl/sig_pack.sv - packs N_WORDS signed WORD_W-bit samples into one wide frame vector
// Optional start-of-frame realignment: define SIG_PACK_SOF_ALIGN_EN.
module sig_pack #(
    parameter int WORD_W  = 65,
    parameter int N_WORDS = 30,
    parameter int IDX_W   = 6
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic signed [WORD_W-1:0]    sig_in,
    input  logic                        sig_valid,
    output logic                        sig_ready,
`ifdef SIG_PACK_SOF_ALIGN_EN
    input  logic                        sig_sof,
    output logic                        align_err,
`endif
    output logic [WORD_W*N_WORDS-1:0]   frame_out,
    output logic                        frame_valid,
    input  logic                        frame_ack,
    output logic                        ovf,
    output logic [15:0]                 frame_cnt
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [IDX_W-1:0]   w_wr_idx;
    logic               w_wr_en;
    logic               w_frame_done;
    logic               w_restart;
    logic [WORD_W-1:0]  r_words [N_WORDS];
    logic [15:0]        r_frame_cnt;
    logic               r_ovf;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= FILL;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_wr_idx     = r_idx;
        w_wr_en      = 1'b0;
        w_frame_done = 1'b0;
        w_restart    = 1'b0;
        case (r_state)
            FILL: begin
                if (sig_valid) begin
                    w_wr_en = 1'b1;
`ifdef SIG_PACK_SOF_ALIGN_EN
                    // A start marker always wins, even on the last slot.
                    if (sig_sof) begin
                        w_wr_idx  = '0;
                        w_idx_nxt = IDX_W'(1);
                        w_restart = 1'b1;
                    end else
`endif
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt    = '0;
                        w_state_nxt  = FULL;
                        w_frame_done = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            FULL: begin
                if (frame_ack) begin
                    w_state_nxt = FILL;
                end
            end
            default: begin
                w_state_nxt = FILL;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Untouched slots keep their previous-frame contents.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < N_WORDS; i++) begin
                r_words[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_WORDS; i++) begin
                if (w_wr_en && (w_wr_idx == IDX_W'(i))) begin
                    r_words[i] <= sig_in;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_frame_cnt <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (sig_valid && (r_state == FULL)) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef SIG_PACK_SOF_ALIGN_EN
    logic r_align_err;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_align_err <= 1'b0;
        end else if (w_restart && (r_idx != '0)) begin
            r_align_err <= 1'b1;
        end
    end

    assign align_err = r_align_err;
`endif

    genvar k;
    generate
        for (k = 0; k < N_WORDS; k++) begin : g_word
            assign frame_out[k*WORD_W +: WORD_W] = r_words[k];
        end
    endgenerate

    assign sig_ready   = (r_state == FILL);
    assign frame_valid = (r_state == FULL);
    assign ovf         = r_ovf;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_sig_pack.sv
// tb/tb_sig_pack.sv - randomized self-checking bench for sig_pack against a frame-level model
module tb_sig_pack;

    localparam int W = 65;
    localparam int N = 30;

    logic               Clk = 1'b0;
    logic               Rst_n = 1'b0;
    logic [W-1:0]       sig_in;
    logic               sig_valid;
    logic               sig_ready;
    logic [W*N-1:0]     frame_out;
    logic               frame_valid;
    logic               frame_ack;
    logic               ovf;
    logic [15:0]        frame_cnt;
`ifdef SIG_PACK_SOF_ALIGN_EN
    logic               sig_sof;
    logic               align_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] m_words [N];
    bit           m_full;
    int           m_n;
    int unsigned  m_cnt;
    bit           m_ovf;
    bit           m_align;

    sig_pack #(.WORD_W(W), .N_WORDS(N), .IDX_W(6)) u_dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .sig_in      (sig_in),
        .sig_valid   (sig_valid),
        .sig_ready   (sig_ready),
`ifdef SIG_PACK_SOF_ALIGN_EN
        .sig_sof     (sig_sof),
        .align_err   (align_err),
`endif
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .ovf         (ovf),
        .frame_cnt   (frame_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        r[31:0]  = $urandom;
        r[63:32] = $urandom;
        r[64]    = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_words[i] = '0;
        m_full  = 1'b0;
        m_n     = 0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_align = 1'b0;
    endtask

    // Frame-level rules: a frame is the next N accepted samples; a full frame blocks input until acked.
    task automatic model_clock();
        if (!m_full) begin
            if (sig_valid) begin
`ifdef SIG_PACK_SOF_ALIGN_EN
                if (sig_sof) begin
                    if (m_n != 0) m_align = 1'b1;
                    m_words[0] = sig_in;
                    m_n = 1;
                end else
`endif
                begin
                    m_words[m_n] = sig_in;
                    m_n++;
                    if (m_n == N) begin
                        m_full = 1'b1;
                        m_n    = 0;
                        m_cnt  = (m_cnt + 1) % 65536;
                    end
                end
            end
        end else begin
            if (sig_valid) m_ovf = 1'b1;
            if (frame_ack) m_full = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_ready"}, sig_ready, !m_full);
        check({tag, "_valid"}, frame_valid, m_full);
        check({tag, "_ovf"}, ovf, m_ovf);
        check({tag, "_cnt"}, frame_cnt, m_cnt[15:0]);
`ifdef SIG_PACK_SOF_ALIGN_EN
        check({tag, "_align"}, align_err, m_align);
`endif
    endtask

    task automatic check_frame(input string tag);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_w%0d", tag, k), frame_out[k*W +: W], m_words[k]);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge after checking outputs.
    task automatic step(input logic v, input logic [W-1:0] d, input logic a, input string tag);
        sig_valid = v;
        sig_in    = d;
        frame_ack = a;
        @(posedge Clk);
        model_clock();
        @(negedge Clk);
        check_outputs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bit prev_full;
        sig_in    = '0;
        sig_valid = 1'b0;
        frame_ack = 1'b0;
`ifdef SIG_PACK_SOF_ALIGN_EN
        sig_sof   = 1'b0;
`endif
        model_reset();
        #2;
        check_outputs("reset");
        check_frame("reset");
        @(negedge Clk);
        Rst_n = 1'b1;

        for (int k = 0; k < N; k++) step(1'b1, W'(k + 1), 1'b0, "basic");
        check("basic_first", frame_out[64:0], 65'd1);
        check("basic_last", frame_out[1949:1885], 65'd30);
        check_frame("basic");

        repeat (10) step(1'b1, rnd(), 1'b0, "bp");
        check_frame("bp_hold");
        step(1'b0, '0, 1'b1, "bp_ack");

        for (int k = 0; k < N; k++)
            step(1'b1, (k % 2 == 0) ? 65'h1_FFFF_FFFF_FFFF_FFFF : 65'h0, 1'b0, "signed");
        check("signed_msb", frame_out[64], 1'b1);
        check_frame("signed");
        step(1'b1, rnd(), 1'b1, "ack_and_valid");

        c = 0;
        while (c < 200 && !m_full) begin
            step(c % 3 == 0, rnd(), 1'($urandom_range(0, 1)), "gap");
            c++;
        end
        check("gap_cycles", c, 88);
        check_frame("gap");
        step(1'b0, '0, 1'b1, "gap_ack");

        prev_full = m_full;
        repeat (300) begin
            step($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 3) == 0, "rand");
            if (m_full && !prev_full) check_frame("rand");
            prev_full = m_full;
        end
        if (m_full) step(1'b0, '0, 1'b1, "rand_ack");

        for (int k = 0; k < 12; k++) step(1'b1, rnd(), 1'b0, "pre_rst");
        Rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        check_frame("async_rst");
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int k = 0; k < N; k++) step(1'b1, rnd(), 1'b0, "post_rst");
        check("post_rst_cnt1", frame_cnt, 16'd1);
        check_frame("post_rst");
        step(1'b0, '0, 1'b1, "post_rst_ack");

`ifdef SIG_PACK_SOF_ALIGN_EN
        for (int k = 0; k < 7; k++) step(1'b1, rnd(), 1'b0, "sof_pre");
        sig_sof = 1'b1;
        step(1'b1, 65'h1_0123_4567_89AB_CDEF, 1'b0, "sof");
        sig_sof = 1'b0;
        check("sof_align", align_err, 1'b1);
        check("sof_word0", frame_out[64:0], 65'h1_0123_4567_89AB_CDEF);
        for (int k = 0; k < 29; k++) step(1'b1, rnd(), 1'b0, "sof_fill");
        check("sof_full", frame_valid, 1'b1);
        check_frame("sof");
        step(1'b0, '0, 1'b1, "sof_ack");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
